// File: rtl/dqla_rt_sampler.sv
// dqla_rt_sampler: captures a coherent snapshot of the dual-QLA read space
// (globals, motors, encoders) into a local buffer, stamped with the timestamp
// taken on the start edge. Optional macro: SAMPLE_DOUBLE_BUFFER_EN selects a
// front/back bank pair so host reads during a capture see the last full set.
//
// state | meaning
// IDLE  | bus released, waiting for sample_start
// ISSUE | one read address per cycle, words 1..N-1
// DRAIN | waiting RD_LAT cycles for the last read data to land
module dqla_rt_sampler #(
    parameter int NUM_MOTORS   = 8,
    parameter int NUM_ENCODERS = 8,
    parameter int RD_LAT       = 2
) (
    input  logic        sysclk,
    input  logic        rstn,
    input  logic        sample_start,
    input  logic [31:0] timestamp,
    input  logic [31:0] bus_rdata,
    output logic [15:0] bus_raddr,
    output logic        sample_busy,
    output logic [3:0]  sample_chan,
    output logic        sample_done,
    output logic        sample_valid,
    input  logic [5:0]  sample_raddr,
    output logic [31:0] sample_rdata
);

    localparam int         N          = 4 + 2 * NUM_MOTORS + 5 * NUM_ENCODERS;
    localparam logic [5:0] LAST_IDX   = 6'(N - 1);
    localparam logic [6:0] N_W        = 7'(N);
    localparam logic [3:0] MOT_LAST   = 4'(NUM_MOTORS);
    localparam logic [1:0] DRAIN_LOAD = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [5:0]  idx, idx_nxt;
    logic [3:0]  chan, chan_nxt;
    logic [3:0]  dev, dev_nxt;
    logic [1:0]  drain_cnt, drain_nxt;
    logic        done_nxt, valid_nxt;
    logic        start_acc, issue_nxt;

    logic [RD_LAT-1:0] pipe_v;
    logic [5:0]        pipe_idx [RD_LAT];

    logic        wr_en;
    logic [5:0]  wr_idx;
    logic [31:0] wr_data;

    // FSM state, address walk counters and status flags
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            idx          <= '0;
            chan         <= '0;
            dev          <= '0;
            drain_cnt    <= '0;
            sample_done  <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            chan         <= chan_nxt;
            dev          <= dev_nxt;
            drain_cnt    <= drain_nxt;
            sample_done  <= done_nxt;
            sample_valid <= valid_nxt;
        end
    end

    // Next-state logic; the address walk follows the channel/device sequence
    // globals (0x0,0xA,0x5) -> motors (0x0,0xC) -> encoders (0x5..0x9)
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        chan_nxt  = chan;
        dev_nxt   = dev;
        drain_nxt = drain_cnt;
        done_nxt  = 1'b0;
        valid_nxt = sample_valid;
        start_acc = 1'b0;
        issue_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sample_start) begin
                    start_acc = 1'b1;
                    issue_nxt = 1'b1;
                    state_nxt = ISSUE;
                    idx_nxt   = 6'd1;
                    chan_nxt  = 4'd0;
                    dev_nxt   = 4'h0;
                end
            end
            ISSUE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end else begin
                    issue_nxt = 1'b1;
                    idx_nxt   = idx + 6'd1;
                    if (chan == 4'd0) begin
                        case (dev)
                            4'h0:    dev_nxt = 4'hA;
                            4'hA:    dev_nxt = 4'h5;
                            default: begin
                                chan_nxt = 4'd1;
                                dev_nxt  = 4'h0;
                            end
                        endcase
                    end else if (dev == 4'h0) begin
                        dev_nxt = 4'hC;
                    end else if (dev == 4'hC) begin
                        if (chan == MOT_LAST) begin
                            chan_nxt = 4'd1;
                            dev_nxt  = 4'h5;
                        end else begin
                            chan_nxt = chan + 4'd1;
                            dev_nxt  = 4'h0;
                        end
                    end else if (dev == 4'h9) begin
                        chan_nxt = chan + 4'd1;
                        dev_nxt  = 4'h5;
                    end else begin
                        dev_nxt = dev + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                end else begin
                    drain_nxt = drain_cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus drive: address only while issuing, released to zero otherwise
    always_comb begin
        sample_busy = (state != IDLE);
        bus_raddr   = (state == ISSUE) ? {8'h00, chan, dev} : 16'h0000;
        sample_chan = (state == ISSUE) ? chan : 4'd0;
    end

    // Write-index pipeline, loaded in step with the address it tags
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_idx[i] <= '0;
        end else begin
            pipe_v[0]   <= issue_nxt;
            pipe_idx[0] <= idx_nxt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    // Word 0 (timestamp) and bus data never collide: the previous capture
    // has fully drained before a new start can be accepted
    always_comb begin
        wr_en   = start_acc | pipe_v[RD_LAT-1];
        wr_idx  = start_acc ? 6'd0 : pipe_idx[RD_LAT-1];
        wr_data = start_acc ? timestamp : bus_rdata;
    end

`ifdef SAMPLE_DOUBLE_BUFFER_EN
    logic        front;
    logic [31:0] mem [128];
    logic [6:0]  wr_ptr, rd_ptr;

    // Banks swap on the edge the capture completes
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) front <= 1'b0;
        else if (done_nxt) front <= ~front;
    end

    assign wr_ptr = {~front, wr_idx};
    assign rd_ptr = {front, sample_raddr};
`else
    logic [31:0] mem [64];
    logic [5:0]  wr_ptr, rd_ptr;

    assign wr_ptr = wr_idx;
    assign rd_ptr = sample_raddr;
`endif

    // Snapshot RAM write port (contents kept across reset, masked by valid)
    always_ff @(posedge sysclk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Registered host read, zero beyond the snapshot or before the first one
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) sample_rdata <= '0;
        else if (sample_valid && ({1'b0, sample_raddr} < N_W)) sample_rdata <= mem[rd_ptr];
        else sample_rdata <= '0;
    end

endmodule

// File: tb/tb_dqla_rt_sampler.sv
// Scoreboard bench for dqla_rt_sampler: three instances (RD_LAT 2, 1, 3)
// share start/timestamp/read address; each has its own bus read model.
module tb_dqla_rt_sampler;

    localparam int N = 60;

    logic        sysclk = 1'b0;
    logic        rstn;
    logic        sample_start;
    logic [31:0] timestamp;
    logic [5:0]  sample_raddr;
    logic [15:0] pat;

    logic [15:0] ra0, ra1, ra3;
    logic [31:0] bd0, bd1, bd3, bd3_s;
    logic        busy0, busy1, busy3;
    logic [3:0]  chan0, chan1, chan3;
    logic        done0, done1, done3;
    logic        valid0, valid1, valid3;
    logic [31:0] rdata0, rdata1, rdata3;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned done_q [3][$];
    logic [31:0] rd_exp_q [$];
    int          busy_until [3] = '{0, 0, 0};
    int          lat [3] = '{2, 1, 3};
    logic        rd_req = 1'b0;
    logic        rd_d = 1'b0;
    logic [2:0]  busy_v, done_v;

    always #10 sysclk = ~sysclk;

    dqla_rt_sampler #(.NUM_MOTORS(8), .NUM_ENCODERS(8), .RD_LAT(2)) u_dut (
        .sysclk(sysclk), .rstn(rstn), .sample_start(sample_start), .timestamp(timestamp),
        .bus_rdata(bd0), .bus_raddr(ra0), .sample_busy(busy0), .sample_chan(chan0),
        .sample_done(done0), .sample_valid(valid0), .sample_raddr(sample_raddr),
        .sample_rdata(rdata0));

    dqla_rt_sampler #(.NUM_MOTORS(8), .NUM_ENCODERS(8), .RD_LAT(1)) u_lat1 (
        .sysclk(sysclk), .rstn(rstn), .sample_start(sample_start), .timestamp(timestamp),
        .bus_rdata(bd1), .bus_raddr(ra1), .sample_busy(busy1), .sample_chan(chan1),
        .sample_done(done1), .sample_valid(valid1), .sample_raddr(sample_raddr),
        .sample_rdata(rdata1));

    dqla_rt_sampler #(.NUM_MOTORS(8), .NUM_ENCODERS(8), .RD_LAT(3)) u_lat3 (
        .sysclk(sysclk), .rstn(rstn), .sample_start(sample_start), .timestamp(timestamp),
        .bus_rdata(bd3), .bus_raddr(ra3), .sample_busy(busy3), .sample_chan(chan3),
        .sample_done(done3), .sample_valid(valid3), .sample_raddr(sample_raddr),
        .sample_rdata(rdata3));

    assign busy_v = {busy3, busy1, busy0};
    assign done_v = {done3, done1, done0};

    // Register bank models: data = {pat, addr}, delayed to match each RD_LAT
    assign bd1 = {pat, ra1};
    always @(posedge sysclk) begin
        bd0   <= {pat, ra0};
        bd3_s <= {pat, ra3};
        bd3   <= bd3_s;
        cyc   <= cyc + 1;
        rd_d  <= rd_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: done pulses against expected cycles, read data against queue
    always @(negedge sysclk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                if (done_q[i].size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: inst %0d pulsed at cycle %0d, required no pulse", i, cyc);
                end else begin
                    chk($sformatf("done_cycle_inst%0d", i), 32'(cyc), 32'(done_q[i].pop_front()));
                end
            end
        end
        if (rd_d) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL read_underflow: read data %h with no expectation", rdata0);
            end else begin
                logic [31:0] e;
                e = rd_exp_q.pop_front();
                chk("rdata_lat2", rdata0, e);
                chk("rdata_lat1", rdata1, e);
                chk("rdata_lat3", rdata3, e);
            end
        end
    end

    task automatic pulse_start();
        int ts;
        @(negedge sysclk);
        sample_start = 1'b1;
        ts = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (ts > busy_until[i]) begin
                busy_until[i] = ts + N - 1 + lat[i];
                done_q[i].push_back(32'(ts + N - 1 + lat[i]));
            end
        end
        @(negedge sysclk);
        sample_start = 1'b0;
    endtask

    task automatic read_word(input logic [5:0] a, input logic [31:0] e);
        @(negedge sysclk);
        sample_raddr = a;
        rd_req = 1'b1;
        rd_exp_q.push_back(e);
        @(negedge sysclk);
        rd_req = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (busy_v != 3'b000 && k < max_cyc) begin
            @(negedge sysclk);
            k++;
        end
        chk("wait_idle_timeout", 32'(busy_v), 32'h0);
        @(negedge sysclk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            done_q[i].delete();
            busy_until[i] = 0;
        end
    endtask

    logic [15:0] exp_addr [6] = '{16'h0000, 16'h000A, 16'h0005, 16'h0010, 16'h001C, 16'h0020};
    logic [3:0]  exp_chan [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
    logic [5:0]  rd_a [11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd20, 6'd58, 6'd59, 6'd60, 6'd63};
    logic [31:0] rd_e [11] = '{32'h12345678, 32'hA5A50000, 32'hA5A5000A, 32'hA5A50005,
                               32'hA5A50010, 32'hA5A5001C, 32'hA5A50015, 32'hA5A50088,
                               32'hA5A50089, 32'h0, 32'h0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn         = 1'b0;
        sample_start = 1'b0;
        timestamp    = 32'h0;
        sample_raddr = 6'd0;
        pat          = 16'hA5A5;
        repeat (3) @(negedge sysclk);
        rstn = 1'b1;
        @(negedge sysclk);

        // Reset state
        chk("reset_busy", 32'(busy_v), 32'h0);
        chk("reset_done", 32'(done_v), 32'h0);
        chk("reset_valid", 32'(valid0), 32'h0);
        chk("reset_bus_raddr", 32'(ra0), 32'h0);
        chk("reset_chan", 32'(chan0), 32'h0);
        chk("reset_rdata", rdata0, 32'h0);
        for (int a = 0; a < 64; a++) read_word(6'(a), 32'h0);

        // Full snapshot, checking the first few issued addresses
        timestamp = 32'h12345678;
        pulse_start();
        timestamp = 32'hDEADBEEF;
        chk("busy_after_start", 32'(busy0), 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk("issue_addr", 32'(ra0), 32'(exp_addr[i]));
            chk("issue_chan", 32'(chan0), 32'(exp_chan[i]));
            @(negedge sysclk);
        end
        wait_idle(200);
        chk("valid_after_done", 32'(valid0), 32'h1);
        for (int i = 0; i < 11; i++) read_word(rd_a[i], rd_e[i]);

        // Retrigger while busy is ignored
        timestamp = 32'h0BADF00D;
        pulse_start();
        timestamp = 32'h11111111;
        repeat (8) @(negedge sysclk);
        pulse_start();
        wait_idle(200);
        read_word(6'd0, 32'h0BADF00D);
        read_word(6'd1, 32'hA5A50000);

        // Reset mid-capture, then a clean snapshot with a new bus pattern
        pat = 16'hC3C3;
        timestamp = 32'h00C0FFEE;
        pulse_start();
        repeat (29) @(negedge sysclk);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midreset_busy", 32'(busy_v), 32'h0);
        chk("midreset_valid", 32'(valid0), 32'h0);
        chk("midreset_bus_raddr", 32'(ra0), 32'h0);
        @(negedge sysclk);
        rstn = 1'b1;
        read_word(6'd1, 32'h0);
        pulse_start();
        wait_idle(200);
        read_word(6'd0, 32'h00C0FFEE);
        read_word(6'd1, 32'hC3C30000);
        read_word(6'd59, 32'hC3C30089);
        read_word(6'd60, 32'h0);
        read_word(6'd63, 32'h0);

`ifdef SAMPLE_DOUBLE_BUFFER_EN
        // Reads during capture B must still return snapshot A
        pat = 16'h7E7E;
        timestamp = 32'h0000BEEF;
        pulse_start();
        read_word(6'd1, 32'hC3C30000);
        read_word(6'd0, 32'h00C0FFEE);
        wait_idle(200);
        read_word(6'd1, 32'h7E7E0000);
        read_word(6'd0, 32'h0000BEEF);
`endif

        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 3; i++) chk("done_queue_empty", 32'(done_q[i].size()), 32'h0);
        chk("read_queue_empty", 32'(rd_exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
